regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port of the 32x32 register file. Shares it between NUM_REQ writeback sources
//  (e.g. ALU, load unit, multi-cycle mul/div) using round-robin arbitration and valid/ready handshakes.
//  Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards against in-flight results.
//  Sits between the writeback sources and the register file; drives its writeEnb/writeReg/writeData.
// PARAMETERS
//  NUM_REQ   3   number of writeback requesters (2..8)
//  DATA_W    32  write data width
//  ADDR_W    5   register address width
//  NUM_REGS  32  registers tracked by the scoreboard (= 2**ADDR_W)
// PORTS
//  clk          in   1               clock; all state updates on posedge
//  rst          in   1               reset, synchronous, active-low
//  req_valid    in   NUM_REQ         requester i has a result to write
//  req_ready    out  NUM_REQ         requester i granted this cycle (one-hot or zero)
//  req_addr     in   NUM_REQ*ADDR_W  packed destination register, slice i = [i*ADDR_W +: ADDR_W]
//  req_data     in   NUM_REQ*DATA_W  packed result data, slice i = [i*DATA_W +: DATA_W]
//  rf_we        out  1               register-file write enable (registered)
//  rf_waddr     out  ADDR_W          register-file write address (registered)
//  rf_wdata     out  DATA_W          register-file write data (registered)
//  issue_valid  in   1               decode issues an instruction that will write issue_addr
//  issue_addr   in   ADDR_W          destination of the issuing instruction
//  issue_stall  out  1               issue_addr already has a pending write; issue is not recorded
//  busy_vec     out  NUM_REGS        scoreboard: bit r = write to register r outstanding
// BEHAVIOUR
//  - Reset (rst==0 at posedge): rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, rr pointer=0.
//    req_ready is forced to 0 combinationally while rst==0. Any in-flight grant is discarded; no write.
//  - Arbitration (combinational): search starts at index ptr, wraps modulo NUM_REQ; first valid wins.
//    req_ready[i]=1 only for the winner; transfer = req_valid[i] & req_ready[i]. No valid -> all 0.
//  - Pointer: on a transfer from i, ptr <= (i+1) mod NUM_REQ; unchanged when no transfer.
//    Guarantees any continuously-valid requester is granted within NUM_REQ cycles.
//  - Write path: latency 1. On transfer, next cycle rf_we=1, rf_waddr/rf_wdata = winner's addr/data.
//    No transfer -> rf_we=0 next cycle; rf_waddr/rf_wdata hold last value.
//  - Register 0: a transfer with addr==0 is accepted (ready asserted) but rf_we stays 0; data dropped.
//  - Requesters must hold valid/addr/data stable until ready; dropping valid early is a protocol error.
//  - Scoreboard set: issue_valid & issue_addr!=0 & !issue_stall -> busy_vec[issue_addr] <= 1.
//  - Scoreboard clear: on a transfer, busy_vec[addr] <= 0 at the same edge rf_we is registered.
//  - issue_stall = issue_valid & busy_vec[issue_addr] & !(transfer to issue_addr this cycle).
//    i.e. a completing write releases its register to a same-cycle issue (clear then set -> busy=1).
//  - Same-cycle set and clear of different registers: both take effect.
//  - Writeback to a register whose busy bit is 0 is still written; busy bit stays 0.
//  - issue_addr==0 never stalls and never sets a bit; busy_vec[0] is constant 0.
//  - All outputs except req_ready and issue_stall are registered.
// STRUCTURE
//  - Shared package regfile_pkg: DATA_W, ADDR_W, NUM_REGS constants; REG_ZERO=5'h0;
//    register name localparams (zero, at, v0.. ra) shared with the register file and decode.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs grant[N] one-hot and grant_idx.
//    Implemented as a rotating-mask double priority encoder. Pointer register lives in the parent.
//  - Parent holds: pointer, output registers, busy_vec, scoreboard set/clear logic.
// TESTING
//  1 Reset: rst=0 for 2 cycles with all req_valid=1 -> req_ready=0, rf_we=0, busy_vec=0.
//  2 Single source: req1 addr=8 data=0xDEADBEEF -> ready1 same cycle, next cycle rf_we=1, waddr=8.
//  3 Contention: all three valid, addrs 9/10/11, held -> grant order 0,1,2,0 with ptr=0.
//    Each requester is granted once per 3 cycles; rf_waddr sequence 9,10,11.
//  4 Reg 0: req0 addr=0 data=5 -> ready0=1, rf_we stays 0, busy_vec unchanged.
//  5 Scoreboard: issue addr=16 -> busy_vec[16]=1; reissue 16 -> issue_stall=1.
//    Writeback to 16 with same-cycle issue 16 -> no stall, busy_vec[16] still 1.
//  6 Mid-op reset: rst=0 the cycle after a grant to addr 12 -> rf_we=0, busy_vec=0, ptr=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Register-file constants and MIPS register names shared by writeback, decode and the register file.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'h0;
  localparam logic [ADDR_W-1:0] REG_AT   = 5'd1;
  localparam logic [ADDR_W-1:0] REG_V0   = 5'd2;
  localparam logic [ADDR_W-1:0] REG_V1   = 5'd3;
  localparam logic [ADDR_W-1:0] REG_A0   = 5'd4;
  localparam logic [ADDR_W-1:0] REG_A1   = 5'd5;
  localparam logic [ADDR_W-1:0] REG_A2   = 5'd6;
  localparam logic [ADDR_W-1:0] REG_A3   = 5'd7;
  localparam logic [ADDR_W-1:0] REG_T0   = 5'd8;
  localparam logic [ADDR_W-1:0] REG_T7   = 5'd15;
  localparam logic [ADDR_W-1:0] REG_S0   = 5'd16;
  localparam logic [ADDR_W-1:0] REG_S7   = 5'd23;
  localparam logic [ADDR_W-1:0] REG_T8   = 5'd24;
  localparam logic [ADDR_W-1:0] REG_T9   = 5'd25;
  localparam logic [ADDR_W-1:0] REG_K0   = 5'd26;
  localparam logic [ADDR_W-1:0] REG_K1   = 5'd27;
  localparam logic [ADDR_W-1:0] REG_GP   = 5'd28;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_FP   = 5'd30;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest requester at or above ptr wins, otherwise lowest overall.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IW = $clog2(N);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] gnt_hi;
  logic [N-1:0] gnt_lo;

  // Two priority encoders: one over the rotated-mask window, one over all requests.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr);
    end
    masked = req & mask;
    gnt_hi = masked & (~masked + N'(1));
    gnt_lo = req & (~req + N'(1));
    grant  = (|masked) ? gnt_hi : gnt_lo;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback sources and tracks in-flight
// destinations so decode can stall on RAW/WAW hazards.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      issue_stall,
  output logic [NUM_REGS-1:0]       busy_vec
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    next_ptr;
  logic [IDX_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  logic                wr_en;
  logic                set_en;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] busy_next;

  logic                we_p1;
  logic [ADDR_W-1:0]   waddr_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [NUM_REGS-1:0] busy_p1;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = rst ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign win_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign win_data  = req_data[grant_idx*DATA_W +: DATA_W];
  assign wr_en     = xfer && (win_addr != REG_ZERO);
  assign next_ptr  = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  // A write completing this cycle releases its register to a same-cycle issue.
  assign issue_stall = issue_valid && busy_p1[issue_addr] && !(xfer && (win_addr == issue_addr));
  assign set_en      = issue_valid && (issue_addr != REG_ZERO) && !issue_stall;

  always_comb begin
    busy_next = busy_p1;
    if (xfer)   busy_next[win_addr]   = 1'b0;
    if (set_en) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Stage p1: registered write port and scoreboard
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      busy_p1  <= '0;
    end else begin
      we_p1   <= wr_en;
      busy_p1 <= busy_next;
      if (xfer) ptr <= next_ptr;
      if (wr_en) begin
        waddr_p1 <= win_addr;
        wdata_p1 <= win_data;
      end
    end
  end

  assign rf_we    = we_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;
  assign busy_vec = busy_p1;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter against a queue/array reference model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              issue_stall;
  logic [NR-1:0]     busy_vec;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_stall (issue_stall),
    .busy_vec    (busy_vec)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Stimulus intent for the next cycle
  bit          s_rst;
  bit          s_v [N];
  int          s_a [N];
  int unsigned s_d [N];
  bit          s_iv;
  int          s_ia;
  int          last_grant;

  // Reference model state
  int          m_ptr;
  bit          m_busy [NR];
  int          m_last_a;
  int unsigned m_last_d;

  typedef struct {
    bit          we;
    int          a;
    int unsigned d;
    logic [NR-1:0] busy;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check combinational outputs, advance the model, queue expected registered state.
  task automatic cycle();
    int win;
    bit stall;
    exp_t e;
    logic [N-1:0] exp_rdy;
    rst = s_rst;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = s_v[i];
      req_addr[i*AW +: AW] = AW'(s_a[i]);
      req_data[i*DW +: DW] = s_d[i];
    end
    issue_valid = s_iv;
    issue_addr  = AW'(s_ia);
    #1;
    win = -1;
    if (s_rst) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && s_v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    stall = s_iv && m_busy[s_ia] && !(win >= 0 && s_a[win] == s_ia);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("issue_stall", 64'(issue_stall), 64'(stall));
    e.we = 1'b0;
    if (!s_rst) begin
      m_ptr = 0;
      for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
      m_last_a = 0;
      m_last_d = 0;
    end else begin
      if (win >= 0) begin
        m_ptr = (win + 1) % N;
        m_busy[s_a[win]] = 1'b0;
        if (s_a[win] != 0) begin
          e.we = 1'b1;
          m_last_a = s_a[win];
          m_last_d = s_d[win];
        end
      end
      if (s_iv && s_ia != 0 && !stall) m_busy[s_ia] = 1'b1;
    end
    e.a = m_last_a;
    e.d = m_last_d;
    for (int r = 0; r < NR; r++) e.busy[r] = m_busy[r];
    expq.push_back(e);
    last_grant = win;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) s_v[i] = 1'b0;
    s_iv = 1'b0;
    s_ia = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rf_we", 64'(rf_we), 64'(e.we));
        chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
        chk("busy_vec", 64'(busy_vec), 64'(e.busy));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin : stimulus
    m_ptr = 0;
    m_last_a = 0;
    m_last_d = 0;
    for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_a[i] = 0;
      s_d[i] = 0;
    end
    idle();

    // Reset held with every requester valid
    s_rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_v[i] = 1'b1;
      s_a[i] = i + 1;
    end
    cycle();
    cycle();
    idle();
    s_rst = 1'b1;

    // Single source
    s_v[1] = 1'b1; s_a[1] = 8; s_d[1] = 32'hDEADBEEF;
    cycle();
    s_v[1] = 1'b0;
    cycle();

    // Contention from ptr=0: grants 0,1,2,0
    s_rst = 1'b0; cycle(); s_rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_v[i] = 1'b1;
      s_a[i] = 9 + i;
      s_d[i] = 32'h1000 + i;
    end
    for (int c = 0; c < 4; c++) cycle();
    idle();
    cycle();

    // Register 0 writeback is accepted and dropped
    s_v[0] = 1'b1; s_a[0] = 0; s_d[0] = 5;
    cycle();
    idle();
    cycle();

    // Scoreboard set, stall, and release to a same-cycle issue
    s_iv = 1'b1; s_ia = 16;
    cycle();
    cycle();
    s_v[1] = 1'b1; s_a[1] = 16; s_d[1] = 32'hCAFE0016;
    cycle();
    idle();
    cycle();

    // Mid-operation reset right after a grant
    s_iv = 1'b1; s_ia = 20;
    s_v[0] = 1'b1; s_a[0] = 12; s_d[0] = 32'h0000_0C0C;
    cycle();
    s_iv = 1'b0;
    s_rst = 1'b0;
    for (int i = 0; i < N; i++) s_v[i] = 1'b1;
    cycle();
    s_rst = 1'b1;
    cycle();
    idle();
    cycle();

    // Randomized traffic with held requests and occasional reset
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_v[i] && ($urandom_range(0, 2) != 0)) begin
          s_v[i] = 1'b1;
          s_a[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NR-1));
          s_d[i] = $urandom;
        end
      end
      s_iv  = ($urandom_range(0, 1) == 1);
      s_ia  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NR-1));
      s_rst = ($urandom_range(0, 59) != 0);
      cycle();
      if (last_grant >= 0) s_v[last_grant] = 1'b0;
    end

    s_rst = 1'b1;
    idle();
    cycle();
    cycle();
    chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
